// File: rtl/sp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_pkg
//  Description : Shared definitions for the I2S receiver: default sample
//                width, channel-filter encodings, FSM state encoding and a
//                channel-filter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sp_pkg;

  // Default sample width in bits.
  localparam int c_data_w_def = 16;

  // Channel-filter encodings for the CH_SEL parameter.
  localparam int c_ch_left  = 0;
  localparam int c_ch_right = 1;
  localparam int c_ch_both  = 2;

  // Receiver FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // True when a word on channel ch (0 left, 1 right) is forwarded under ch_sel.
  function automatic logic ch_pass(input int ch_sel, input logic ch);
    return (ch_sel == c_ch_both) ||
           ((ch_sel == c_ch_left)  && !ch) ||
           ((ch_sel == c_ch_right) &&  ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_if
//  Description : Bundle of the I2S receiver signals.
//                enable/i2s_bclk/i2s_ws/i2s_sd : serial side and enable
//                sample_out/sample_valid/sample_ch/frame_err : sample side
//                master : drives the serial side, observes samples
//                slave  : the receiver itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2s_rx_if
  import sp_pkg::*;
#(
  parameter int DATA_W = c_data_w_def
);
  logic              enable;
  logic              i2s_bclk;
  logic              i2s_ws;
  logic              i2s_sd;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sample_ch;
  logic              frame_err;

  modport master (
    output enable, i2s_bclk, i2s_ws, i2s_sd,
    input  sample_out, sample_valid, sample_ch, frame_err
  );

  modport slave (
    input  enable, i2s_bclk, i2s_ws, i2s_sd,
    output sample_out, sample_valid, sample_ch, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit.
//                clk   : destination clock
//                rst_n : asynchronous active-low reset (clears both flops)
//                d_i   : asynchronous input
//                q_o   : synchronized output
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx
//  Description : Philips-format I2S receiver, oversampled by clk.
//                clk   : system clock (>= 4x bit clock)
//                rst_n : asynchronous active-low reset
//                bus   : i2s_rx_if.slave - enable, I2S serial inputs,
//                        sample_out/sample_valid/sample_ch/frame_err
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx
  import sp_pkg::*;
#(
  parameter int DATA_W = c_data_w_def,
  parameter int CH_SEL = c_ch_left
) (
  input  logic     clk,
  input  logic     rst_n,
  i2s_rx_if.slave  bus
);
  localparam int                 c_cnt_w    = $clog2(DATA_W + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DATA_W);

  logic w_bclk_s, w_ws_s, w_sd_s;

  sync_2ff u_sync_bclk (.clk(clk), .rst_n(rst_n), .d_i(bus.i2s_bclk), .q_o(w_bclk_s));
  sync_2ff u_sync_ws   (.clk(clk), .rst_n(rst_n), .d_i(bus.i2s_ws),   .q_o(w_ws_s));
  sync_2ff u_sync_sd   (.clk(clk), .rst_n(rst_n), .d_i(bus.i2s_sd),   .q_o(w_sd_s));

  logic bclk_prev_q;
  logic ws_prev_q;
  logic w_bclk_rise;
  logic w_ws_chg;

  assign w_bclk_rise = w_bclk_s & ~bclk_prev_q;
  assign w_ws_chg    = w_bclk_rise & (w_ws_s != ws_prev_q);

  // ws history keeps tracking while disabled, so a re-enable in the middle
  // of a slot is never mistaken for a word boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_prev_q <= 1'b0;
      ws_prev_q   <= 1'b0;
    end else begin
      bclk_prev_q <= w_bclk_s;
      if (w_bclk_rise) ws_prev_q <= w_ws_s;
    end
  end

  state_e              state_q, state_d;
  logic [c_cnt_w-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                ch_q, ch_d;
  logic [DATA_W-1:0]   sample_out_q, sample_out_d;
  logic                sample_ch_q, sample_ch_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   w_shifted;
  logic [c_cnt_w-1:0]  w_cnt_inc;

  assign w_shifted = {shreg_q[DATA_W-2:0], w_sd_s};
  assign w_cnt_inc = bit_cnt_q + c_cnt_w'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      ch_q         <= 1'b0;
      sample_out_q <= '0;
      sample_ch_q  <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      ch_q         <= ch_d;
      sample_out_q <= sample_out_d;
      sample_ch_q  <= sample_ch_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    ch_d         = ch_q;
    sample_out_d = sample_out_q;
    sample_ch_d  = sample_ch_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_ws_chg) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            shreg_d   = '0;
            ch_d      = w_ws_s;
          end
        end
        ST_SHIFT: begin
          if (w_bclk_rise) begin
            // The bit sampled on a ws-change event is still the current
            // word's LSB, so it is shifted in before the boundary is judged.
            shreg_d   = w_shifted;
            bit_cnt_d = w_cnt_inc;
            if (w_cnt_inc == c_cnt_full) begin
              state_d = ST_HOLD;
              if (ch_pass(CH_SEL, ch_q)) begin
                sample_out_d = w_shifted;
                sample_ch_d  = ch_q;
                valid_d      = 1'b1;
              end
            end
            if (w_ws_chg) begin
              err_d     = (w_cnt_inc != c_cnt_full);
              state_d   = ST_SHIFT;
              bit_cnt_d = '0;
              shreg_d   = '0;
              ch_d      = w_ws_s;
            end
          end
        end
        ST_HOLD: begin
          if (w_ws_chg) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            shreg_d   = '0;
            ch_d      = w_ws_s;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.sample_out   = sample_out_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;
endmodule
`default_nettype wire

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits, captured MSB-first.
REQ-002 Parameter CH_SEL, default 0: channel filter; 0 = left only, 1 = right only, 2 = both.
REQ-003 clk  input  1  system clock; SHALL run at least 4x the i2s_bclk frequency.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  receiver enable; low forces IDLE.
REQ-006 i2s_bclk  input  1  I2S bit clock, asynchronous to clk.
REQ-007 i2s_ws  input  1  word select; 0 = left, 1 = right.
REQ-008 i2s_sd  input  1  serial data, valid on the i2s_bclk rising edge.
REQ-009 sample_out  output  DATA_W  last captured sample, two's complement, held until the next capture.
REQ-010 sample_valid  output  1  one-clk pulse marking a new sample_out.
REQ-011 sample_ch  output  1  channel of sample_out (0 left, 1 right).
REQ-012 frame_err  output  1  one-clk pulse on a truncated word.

Function
REQ-013 i2s_bclk, i2s_ws and i2s_sd SHALL each pass through a 2-flop synchronizer.
REQ-014 A bclk rise event SHALL be a one-clk pulse when synced bclk is 1 and its previous registered value was 0; ws and sd SHALL be sampled only on this pulse.
REQ-015 A ws change SHALL be the sampled ws differing from the ws sampled at the previous rise event; Philips timing applies, so the bit sampled at that event is the prior word's LSB and the next event carries the new MSB.
REQ-016 The FSM SHALL have states IDLE, SHIFT and HOLD.
REQ-017 IDLE: ignore data; on a ws change go to SHIFT with bit_cnt=0 and ch=new ws.
REQ-018 SHIFT: on each rise event after entry, shift sd into the LSB of shreg and increment bit_cnt; when bit_cnt reaches DATA_W, go to HOLD.
REQ-019 On the SHIFT-to-HOLD transition, the next clk SHALL load sample_out=shreg and sample_ch=ch, and pulse sample_valid, but only if ch passes CH_SEL.
REQ-020 HOLD: ignore bits beyond DATA_W (slots longer than DATA_W); on a ws change go to SHIFT with bit_cnt=0 and ch=new ws.
REQ-021 A ws change in SHIFT with bit_cnt<DATA_W SHALL discard shreg, pulse frame_err for one clk, and restart SHIFT for the new channel.
REQ-022 Latency: sample_valid SHALL assert exactly 1 clk after the rise-event pulse that captured the final bit.
REQ-023 enable low SHALL force IDLE within 1 clk, suppress sample_valid and frame_err, and keep sample_out unchanged.
REQ-024 After enable rises, capture SHALL begin only at the next ws change, so no partial word is ever output.
REQ-025 sample_valid and frame_err SHALL never assert in the same clk.

Reset
REQ-026 rst_n low SHALL immediately clear sample_out=0, sample_valid=0, sample_ch=0, frame_err=0, shreg=0, bit_cnt=0, all synchronizer and edge flops, and set state=IDLE.
REQ-027 Reset mid-word SHALL discard the word; after release, the first output SHALL be a full word that begins after a ws change.

Structure
REQ-028 DATA_W default, the CH_SEL encodings and the FSM state encoding SHALL reside in shared package sp_pkg.
REQ-029 The 2-flop synchronizer SHALL be sub-module sync_2ff, instantiated three times.
REQ-030 Implementation SHALL be synthesizable, single clock domain (clk), with no latches.

Verification
REQ-031 clk=8x bclk, CH_SEL=0, left word 0xA5C3 in a 16-bit slot -> one sample_valid pulse, sample_out=0xA5C3, sample_ch=0, frame_err=0.
REQ-032 CH_SEL=2, 32-bit slots, left upper bits 0x1234, right upper bits 0x8001, lower bits random -> two valids: 0x1234/ch0, then 0x8001/ch1.
REQ-033 CH_SEL=0, right word 0x7FFF -> no sample_valid; sample_out keeps the previous value.
REQ-034 ws toggles after 10 bits of a left word -> one frame_err pulse, no valid; the following full right word 0x00FF with CH_SEL=2 -> valid with 0x00FF/ch1.
REQ-035 rst_n pulsed low after bit 8 of 0xFFFF -> all outputs 0 at once; the next full word 0x5A5A -> single valid with 0x5A5A, and no stale bits.
REQ-036 enable dropped mid-word then raised mid-slot -> no valid or frame_err for the interrupted and partial slots; the first valid comes on the next complete word.
